// File: rtl/lanes_pkg.sv
// Shared definitions for the two-lane striping and unstriping stages.
// State and lane-valid encodings are common to both ends of the path.
package lanes_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_e;

  localparam logic [1:0] PAIR  = 2'b11;
  localparam logic [1:0] LONE0 = 2'b10;
  localparam logic [1:0] NONE  = 2'b00;

endpackage

// File: rtl/lane_striper.sv
// Steers consecutive valid words alternately into lane 0 and lane 1,
// flushing a lone lane-0 word when its partner is late.
module lane_striper #(
  parameter int DATA_W  = lanes_pkg::DATA_W,
  parameter int TIMEOUT = 4,
  parameter int TMR_W   = 3
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_0,
  output logic              valid_1,
  output logic              pending
);

  import lanes_pkg::*;

  localparam bit FLUSH_EN = (TIMEOUT > 0);
  localparam int LAST_I   = FLUSH_EN ? TIMEOUT - 1 : 0;
  localparam logic [TMR_W-1:0] TMR_LAST = LAST_I[TMR_W-1:0];

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] lane0_q, lane0_d;
  logic [DATA_W-1:0] lane1_q, lane1_d;
  logic [1:0]        vld_q, vld_d;

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
      timer_q <= '0;
      lane0_q <= '0;
      lane1_q <= '0;
      vld_q   <= NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    lane0_d = lane0_q;
    lane1_d = lane1_q;
    vld_d   = NONE;
    unique case (state_q)
      ST_EMPTY: begin
        if (valid_in) begin
          hold_d  = data_in;
          timer_d = '0;
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        // A partner arriving on the expiry cycle beats the flush.
        if (valid_in) begin
          lane0_d = hold_q;
          lane1_d = data_in;
          vld_d   = PAIR;
          timer_d = '0;
          state_d = ST_EMPTY;
        end else if (FLUSH_EN && timer_q == TMR_LAST) begin
          lane0_d = hold_q;
          lane1_d = '0;
          vld_d   = LONE0;
          timer_d = '0;
          state_d = ST_EMPTY;
        end else if (FLUSH_EN) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign lane_0  = lane0_q;
  assign lane_1  = lane1_q;
  assign valid_0 = vld_q[1];
  assign valid_1 = vld_q[0];
  assign pending = (state_q == ST_HALF);

endmodule

// File: tb/tb_lane_striper.sv
// Scoreboard bench for lane_striper: expected lane events are queued
// as words are driven and popped when the valids pulse.
module tb_lane_striper;

  logic        clk_2f;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic [31:0] lane_0;
  logic [31:0] lane_1;
  logic        valid_0;
  logic        valid_1;
  logic        pending;

  int tests;
  int fails;
  int pairs;
  logic [65:0] sb[$];

  lane_striper #(.DATA_W(32), .TIMEOUT(4), .TMR_W(3)) dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .data_in (data_in),
    .valid_in(valid_in),
    .lane_0  (lane_0),
    .lane_1  (lane_1),
    .valid_0 (valid_0),
    .valid_1 (valid_1),
    .pending (pending)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic cyc(input logic v, input logic [31:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic test_reset();
    reset_L  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(i[0], 32'hA5A5_0000 + 32'(i));
      tests++;
      if ({valid_0, valid_1, pending, lane_0, lane_1} !== 67'd0) begin
        fails++;
        $display("FAIL reset_hold: v=%b%b p=%b l0=%h l1=%h want all 0",
                 valid_0, valid_1, pending, lane_0, lane_1);
      end
    end
    valid_in = 1'b0;
    @(negedge clk_2f);
    reset_L = 1'b1;
    #1;
  endtask

  task automatic test_pairs();
    logic [31:0] w[4];
    logic [65:0] e;
    w[0] = 32'h0000FFFF; w[1] = 32'hFFFFFFFF;
    w[2] = 32'h00000000; w[3] = 32'h0000FFFF;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 1) sb.push_back({2'b11, w[i-1], w[i]});
      cyc(1'b1, w[i]);
      tests++;
      if (valid_0 | valid_1) begin
        e = (sb.size() != 0) ? sb.pop_front() : 66'd0;
        if ({valid_0, valid_1, lane_0, lane_1} !== e) begin
          fails++;
          $display("FAIL pairs[%0d]: got %b%b %h %h want %h",
                   i, valid_0, valid_1, lane_0, lane_1, e);
        end
      end else if (sb.size() != 0) begin
        fails++;
        $display("FAIL pairs[%0d]: no valid, want %h", i, sb[0]);
        void'(sb.pop_front());
      end
    end
    cyc(1'b0, 32'h0);
    tests++;
    if ({valid_0, valid_1, pending} !== 3'b000) begin
      fails++;
      $display("FAIL pairs_idle: v=%b%b p=%b want 000",
               valid_0, valid_1, pending);
    end
  endtask

  task automatic test_gap();
    logic [65:0] e;
    cyc(1'b1, 32'h0000FFFF);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 32'hDEADBEEF);
      tests++;
      if ({valid_0, valid_1, pending} !== 3'b001) begin
        fails++;
        $display("FAIL gap_idle[%0d]: v=%b%b p=%b want 001",
                 i, valid_0, valid_1, pending);
      end
    end
    sb.push_back({2'b11, 32'h0000FFFF, 32'h00000000});
    cyc(1'b1, 32'h00000000);
    e = sb.pop_front();
    tests++;
    if ({valid_0, valid_1, lane_0, lane_1} !== e) begin
      fails++;
      $display("FAIL gap_pair: got %b%b %h %h want %h",
               valid_0, valid_1, lane_0, lane_1, e);
    end
  endtask

  task automatic test_flush();
    logic [65:0] e;
    cyc(1'b1, 32'hFFFFFFFF);
    tests++;
    if (pending !== 1'b1) begin
      fails++;
      $display("FAIL flush_pend: got %b want 1", pending);
    end
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) sb.push_back({2'b10, 32'hFFFFFFFF, 32'h0});
      cyc(1'b0, 32'h1111_1111);
      tests++;
      if (valid_0 | valid_1) begin
        e = (sb.size() != 0) ? sb.pop_front() : 66'd0;
        if ({valid_0, valid_1, lane_0, lane_1, pending} !== {e, 1'b0}) begin
          fails++;
          $display("FAIL flush[%0d]: got %b%b %h %h p=%b want %h p=0",
                   i, valid_0, valid_1, lane_0, lane_1, pending, e);
        end
      end else if (sb.size() != 0 || pending !== 1'b1) begin
        fails++;
        $display("FAIL flush[%0d]: v=00 p=%b want flush=%0d p=1",
                 i, pending, sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_collision();
    logic [65:0] e;
    cyc(1'b1, 32'hCAFE0001);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0);
    sb.push_back({2'b11, 32'hCAFE0001, 32'h12345678});
    cyc(1'b1, 32'h12345678);
    e = sb.pop_front();
    tests++;
    if ({valid_0, valid_1, lane_0, lane_1} !== e) begin
      fails++;
      $display("FAIL collision: got %b%b %h %h want %h",
               valid_0, valid_1, lane_0, lane_1, e);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'h0);
      tests++;
      if ({valid_0, valid_1, pending} !== 3'b000) begin
        fails++;
        $display("FAIL collision_after[%0d]: v=%b%b p=%b want 000",
                 i, valid_0, valid_1, pending);
      end
    end
  endtask

  task automatic test_steering();
    logic        vv[6];
    logic [31:0] dd[6];
    logic [65:0] e;
    vv[0] = 1; vv[1] = 0; vv[2] = 1; vv[3] = 1; vv[4] = 0; vv[5] = 1;
    for (int i = 0; i < 6; i++) dd[i] = 32'hB000_0000 + 32'(i);
    pairs = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) sb.push_back({2'b11, dd[0], dd[2]});
      if (i == 5) sb.push_back({2'b11, dd[3], dd[5]});
      cyc(vv[i], dd[i]);
      if (valid_0 & valid_1) pairs++;
      tests++;
      if (valid_0 | valid_1) begin
        e = (sb.size() != 0) ? sb.pop_front() : 66'd0;
        if ({valid_0, valid_1, lane_0, lane_1} !== e) begin
          fails++;
          $display("FAIL steer[%0d]: got %b%b %h %h want %h",
                   i, valid_0, valid_1, lane_0, lane_1, e);
        end
      end else if (sb.size() != 0) begin
        fails++;
        $display("FAIL steer[%0d]: no valid, want %h", i, sb[0]);
        void'(sb.pop_front());
      end
    end
    cyc(1'b0, 32'h0);
    tests++;
    if (pairs !== 2) begin
      fails++;
      $display("FAIL steer_count: got %0d pairs want 2", pairs);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 32'h77777777);
    tests++;
    if (pending !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pend: got %b want 1", pending);
    end
    valid_in = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    tests++;
    if (pending !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async: pending=%b want 0", pending);
    end
    @(negedge clk_2f);
    reset_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 32'h0);
      tests++;
      if ({valid_0, valid_1, pending} !== 3'b000) begin
        fails++;
        $display("FAIL rst_mid_after[%0d]: v=%b%b p=%b want 000",
                 i, valid_0, valid_1, pending);
      end
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    pairs    = 0;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    test_reset();
    test_pairs();
    test_gap();
    test_flush();
    test_collision();
    test_steering();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
